// File: rtl/fll_cfg_regs.sv
// Register target for one FLL native configuration port: req/ack handshake with
// configurable latency, CONFIG1/CONFIG2/INTEGRATOR storage and a modelled lock.
module fll_cfg_regs #(
    parameter int unsigned ACK_WAIT = 2,
    parameter logic [31:0] CFG1_RST = 32'h8400_05F5,
    parameter logic [31:0] CFG2_RST = 32'h0000_0144,
    parameter logic [31:0] INT_RST  = 32'h0000_0000
) (
    input  logic        clk_i,
    input  logic        rst_ni,
    input  logic        fll_req_i,
    input  logic        fll_wrn_i,
    input  logic [1:0]  fll_add_i,
    input  logic [31:0] fll_data_i,
    output logic        fll_ack_o,
    output logic [31:0] fll_r_data_o,
    output logic        fll_lock_o,
    output logic [15:0] cfg_mult_o,
    output logic [3:0]  cfg_div_o
);

    localparam logic [31:0] CFG1_MASK = 32'hBFFF_FFFF;
    localparam logic [31:0] INT_MASK  = 32'h03FF_03FF;
    localparam logic [3:0]  WAIT_INIT = 4'(ACK_WAIT);

    localparam logic [1:0] ADDR_STATUS = 2'd0;
    localparam logic [1:0] ADDR_CFG1   = 2'd1;
    localparam logic [1:0] ADDR_CFG2   = 2'd2;
    localparam logic [1:0] ADDR_INTEG  = 2'd3;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_WAIT,
        ST_ACK,
        ST_DONE
    } state_t;

    state_t      state;
    logic [3:0]  wait_cnt;
    logic        wrn_q;
    logic [1:0]  add_q;
    logic [31:0] data_q;
    logic [31:0] cfg1;
    logic [31:0] cfg2;
    logic [31:0] integ;
    logic        mf_reload;
    logic [11:0] settle_cnt;
    logic [31:0] status_word;

    assign status_word = {16'h0000, (fll_lock_o ? cfg1[15:0] : 16'h0000)};

    // Handshake FSM; the register access itself happens on the edge that raises ack.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            // NOTE: the register file is a handful of flops with defined power-up values, so it is reset like any other state.
            state        <= ST_IDLE;
            wait_cnt     <= '0;
            wrn_q        <= 1'b1;
            add_q        <= '0;
            data_q       <= '0;
            fll_ack_o    <= 1'b0;
            fll_r_data_o <= '0;
            cfg1         <= CFG1_RST & CFG1_MASK;
            cfg2         <= CFG2_RST;
            integ        <= INT_RST & INT_MASK;
            mf_reload    <= 1'b0;
        end else begin
            mf_reload <= 1'b0;
            unique case (state)
                ST_IDLE: begin
                    if (fll_req_i) begin
                        wrn_q    <= fll_wrn_i;
                        add_q    <= fll_add_i;
                        data_q   <= fll_data_i;
                        wait_cnt <= WAIT_INIT;
                        state    <= ST_WAIT;
                    end
                end
                ST_WAIT: begin
                    if (wait_cnt != '0) begin
                        wait_cnt <= wait_cnt - 4'd1;
                    end else begin
                        fll_ack_o <= 1'b1;
                        state     <= ST_ACK;
                        if (wrn_q) begin
                            case (add_q)
                                ADDR_STATUS: fll_r_data_o <= status_word;
                                ADDR_CFG1:   fll_r_data_o <= cfg1;
                                ADDR_CFG2:   fll_r_data_o <= cfg2;
                                default:     fll_r_data_o <= integ;
                            endcase
                        end else begin
                            case (add_q)
                                ADDR_CFG1: begin
                                    cfg1 <= data_q & CFG1_MASK;
                                    // NOTE: non-blocking update, so cfg1 here is still the value before this write.
                                    mf_reload <= (data_q[15:0] != cfg1[15:0]);
                                end
                                ADDR_CFG2:  cfg2  <= data_q;
                                ADDR_INTEG: integ <= data_q & INT_MASK;
                                default: ; // STATUS is read-only; the write is acked and dropped
                            endcase
                        end
                    end
                end
                ST_ACK: begin
                    if (!fll_req_i) begin
                        fll_ack_o    <= 1'b0;
                        fll_r_data_o <= '0;
                        state        <= ST_DONE;
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

    // Settle model: a new MF restarts the count one cycle after the write lands.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            fll_lock_o <= 1'b0;
            settle_cnt <= CFG2_RST[15:4];
        end else if (mf_reload) begin
            fll_lock_o <= 1'b0;
            settle_cnt <= cfg2[15:4];
        end else if (!fll_lock_o) begin
            if (settle_cnt == '0) begin
                fll_lock_o <= 1'b1;
            end else begin
                settle_cnt <= settle_cnt - 12'd1;
            end
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            cfg_mult_o <= CFG1_RST[15:0];
            cfg_div_o  <= CFG1_RST[29:26];
        end else begin
            cfg_mult_o <= cfg1[15:0];
            cfg_div_o  <= cfg1[29:26];
        end
    end

endmodule

// File: tb/tb_fll_cfg_regs.sv
// Directed bench for fll_cfg_regs: one instance with ACK_WAIT=2 for the register
// and lock behaviour, one with ACK_WAIT=3 for the short-request corner case.
module tb_fll_cfg_regs;

    logic        clk_i = 1'b0;
    logic        rst_ni;
    logic        req_a, req_b, wrn;
    logic [1:0]  add;
    logic [31:0] data;
    logic        ack_a, ack_b, lock_a, lock_b;
    logic [31:0] rd_a, rd_b;
    logic [15:0] mult_a, mult_b;
    logic [3:0]  div_a, div_b;

    always #5 clk_i = ~clk_i;

    fll_cfg_regs #(.ACK_WAIT(2)) dut_a (
        .clk_i(clk_i), .rst_ni(rst_ni), .fll_req_i(req_a), .fll_wrn_i(wrn),
        .fll_add_i(add), .fll_data_i(data), .fll_ack_o(ack_a), .fll_r_data_o(rd_a),
        .fll_lock_o(lock_a), .cfg_mult_o(mult_a), .cfg_div_o(div_a)
    );

    fll_cfg_regs #(.ACK_WAIT(3)) dut_b (
        .clk_i(clk_i), .rst_ni(rst_ni), .fll_req_i(req_b), .fll_wrn_i(wrn),
        .fll_add_i(add), .fll_data_i(data), .fll_ack_o(ack_b), .fll_r_data_o(rd_b),
        .fll_lock_o(lock_b), .cfg_mult_o(mult_b), .cfg_div_o(div_b)
    );

    int   n_checks = 0;
    int   n_fail   = 0;
    int   cyc      = 0;
    int   lock_rise = 0;
    int   lock_fall = 0;
    logic lock_prev = 1'b0;

    // Edge counter for dut_a: cyc=1 on the first rising edge after reset release.
    always @(posedge clk_i) begin
        #1;
        if (!rst_ni) begin
            cyc       = 0;
            lock_rise = 0;
            lock_fall = 0;
        end else begin
            cyc++;
            if (lock_a && !lock_prev) lock_rise = cyc;
            if (!lock_a && lock_prev) lock_fall = cyc;
        end
        lock_prev = lock_a;
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
        end
    endtask

    // One four-phase transaction; returns read data, the edge index of the access and the latency.
    task automatic xfer(input bit sel, input logic w, input logic [1:0] a, input logic [31:0] d,
                        output logic [31:0] rdata, output int wcyc);
        bit got;
        int lat;
        got   = 1'b0;
        lat   = -1;
        rdata = '0;
        wcyc  = -1;
        wrn   = w;
        add   = a;
        data  = d;
        if (sel) req_b = 1'b1; else req_a = 1'b1;
        for (int i = 1; i <= 20 && !got; i++) begin
            @(negedge clk_i);
            if (sel ? ack_b : ack_a) begin
                got   = 1'b1;
                lat   = i - 1;
                rdata = sel ? rd_b : rd_a;
                wcyc  = cyc;
            end
        end
        req_a = 1'b0;
        req_b = 1'b0;
        check(sel ? "latency_b" : "latency_a", lat, sel ? 4 : 3);
        @(negedge clk_i);
        check("ack_falls", sel ? ack_b : ack_a, 1'b0);
        check("rdata_cleared", sel ? rd_b : rd_a, 32'h0);
        @(negedge clk_i);
    endtask

    task automatic wait_lock(input string name, input int exp);
        bit got;
        got = 1'b0;
        for (int i = 0; i < 300 && !got; i++) begin
            if (lock_a) got = 1'b1;
            else @(negedge clk_i);
        end
        check(name, got ? lock_rise : -1, exp);
    endtask

    typedef struct {
        logic        w;
        logic [1:0]  a;
        logic [31:0] d;
        logic        chk;
        logic [31:0] exp;
        string       name;
    } vec_t;

    vec_t        vecs[10];
    logic [31:0] rd;
    int          w1, w2, first, hi;
    bit          ack_seen;

    initial begin
        vecs[0] = '{1'b1, 2'd0, 32'h0,         1'b1, 32'h0000_05F5, "rd_status_locked"};
        vecs[1] = '{1'b0, 2'd1, 32'hC800_05F5, 1'b0, 32'h0,         "wr_cfg1_same_mf"};
        vecs[2] = '{1'b1, 2'd1, 32'h0,         1'b1, 32'h8800_05F5, "rd_cfg1_bit30_zero"};
        vecs[3] = '{1'b1, 2'd0, 32'h0,         1'b1, 32'h0000_05F5, "rd_status_still_locked"};
        vecs[4] = '{1'b0, 2'd3, 32'hFFFF_FFFF, 1'b0, 32'h0,         "wr_integ"};
        vecs[5] = '{1'b1, 2'd3, 32'h0,         1'b1, 32'h03FF_03FF, "rd_integ_masked"};
        vecs[6] = '{1'b0, 2'd0, 32'h0000_1234, 1'b0, 32'h0,         "wr_status"};
        vecs[7] = '{1'b1, 2'd0, 32'h0,         1'b1, 32'h0000_05F5, "rd_status_unchanged"};
        vecs[8] = '{1'b0, 2'd2, 32'hABCD_0144, 1'b0, 32'h0,         "wr_cfg2"};
        vecs[9] = '{1'b1, 2'd2, 32'h0,         1'b1, 32'hABCD_0144, "rd_cfg2"};

        rst_ni = 1'b0;
        req_a  = 1'b0;
        req_b  = 1'b0;
        wrn    = 1'b1;
        add    = '0;
        data   = '0;
        repeat (3) @(negedge clk_i);
        check("rst_ack", ack_a, 1'b0);
        check("rst_rdata", rd_a, 32'h0);
        check("rst_lock", lock_a, 1'b0);
        check("rst_mult", mult_a, 16'h05F5);
        check("rst_div", div_a, 4'd1);
        rst_ni = 1'b1;

        wait_lock("lock_after_reset", 21);

        foreach (vecs[i]) begin
            xfer(1'b0, vecs[i].w, vecs[i].a, vecs[i].d, rd, w1);
            if (vecs[i].chk) check(vecs[i].name, rd, vecs[i].exp);
        end
        check("no_unlock_same_mf", lock_fall, 0);
        check("div_after_same_mf", div_a, 4'd2);

        // New MF with lock_cnt=0x014.
        xfer(1'b0, 1'b0, 2'd1, 32'h8800_0100, rd, w1);
        check("mf_unlock_edge", lock_fall, w1 + 1);
        check("mult_new", mult_a, 16'h0100);
        check("div_new", div_a, 4'd2);
        xfer(1'b0, 1'b1, 2'd0, 32'h0, rd, w2);
        check("status_settling", rd, 32'h0);
        wait_lock("relock_cnt20", w1 + 22);
        xfer(1'b0, 1'b1, 2'd0, 32'h0, rd, w2);
        check("status_relocked", rd, 32'h0000_0100);

        // lock_cnt=3, then lock_cnt=0.
        xfer(1'b0, 1'b0, 2'd2, 32'h0000_0034, rd, w2);
        xfer(1'b0, 1'b0, 2'd1, 32'h8800_0200, rd, w1);
        check("unlock_cnt3", lock_fall, w1 + 1);
        wait_lock("relock_cnt3", w1 + 5);
        xfer(1'b0, 1'b0, 2'd2, 32'h0000_0004, rd, w2);
        xfer(1'b0, 1'b0, 2'd1, 32'h8800_0300, rd, w1);
        check("unlock_cnt0", lock_fall, w1 + 1);
        wait_lock("relock_cnt0", w1 + 2);

        // lock_cnt=10: a second CONFIG1 write during settling restarts the count.
        xfer(1'b0, 1'b0, 2'd2, 32'h0000_00A4, rd, w2);
        xfer(1'b0, 1'b0, 2'd1, 32'h8800_0400, rd, w1);
        xfer(1'b0, 1'b0, 2'd1, 32'h8800_0500, rd, w2);
        check("restart_unlock", lock_fall, w1 + 1);
        wait_lock("restart_relock", w2 + 12);

        // A CONFIG2 write mid-settle leaves the running count alone, then applies next reload.
        xfer(1'b0, 1'b0, 2'd1, 32'h8800_0600, rd, w1);
        xfer(1'b0, 1'b0, 2'd2, 32'h0000_0024, rd, w2);
        wait_lock("cfg2_no_restart", w1 + 12);
        xfer(1'b0, 1'b0, 2'd1, 32'h8800_0700, rd, w1);
        wait_lock("cfg2_next_reload", w1 + 4);

        // ACK_WAIT=3, request held for a single cycle.
        wrn   = 1'b0;
        add   = 2'd1;
        data  = 32'h8400_0777;
        req_b = 1'b1;
        @(negedge clk_i);
        req_b = 1'b0;
        first = -1;
        hi    = 0;
        for (int j = 1; j <= 10; j++) begin
            @(negedge clk_i);
            if (ack_b) begin
                hi++;
                if (first < 0) first = j;
            end
        end
        check("short_req_ack_edge", first, 4);
        check("short_req_ack_len", hi, 1);
        check("short_req_mult", mult_b, 16'h0777);
        xfer(1'b1, 1'b1, 2'd1, 32'h0, rd, w1);
        check("short_req_landed", rd, 32'h8400_0777);

        // Reset during WAIT of a CONFIG1 write.
        wrn   = 1'b0;
        add   = 2'd1;
        data  = 32'h8800_0999;
        req_a = 1'b1;
        @(negedge clk_i);
        rst_ni = 1'b0;
        #1;
        check("midrst_ack", ack_a, 1'b0);
        check("midrst_lock", lock_a, 1'b0);
        req_a    = 1'b0;
        ack_seen = 1'b0;
        repeat (3) begin
            @(negedge clk_i);
            ack_seen = ack_seen | ack_a;
        end
        rst_ni = 1'b1;
        repeat (4) begin
            @(negedge clk_i);
            ack_seen = ack_seen | ack_a;
        end
        check("midrst_no_ack", ack_seen, 1'b0);
        check("midrst_mult", mult_a, 16'h05F5);
        xfer(1'b0, 1'b1, 2'd1, 32'h0, rd, w1);
        check("midrst_cfg1", rd, 32'h8400_05F5);
        wait_lock("midrst_relock", 21);

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
